// File: rtl/input_mem_loader.sv
// Packs 32-bit upstream words into 128-bit memory lines and writes each line
// with a single-cycle registered write strobe; short final lines are masked.
module input_mem_loader #(
    parameter int NUM_WORD = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              START,
    input  logic              IN_VALID,
    input  logic [31:0]       IN_DATA,
    input  logic              IN_LAST,
    output logic              IN_READY,
    output logic              CEB,
    output logic              WEB,
    output logic [ADDR_W-1:0] A,
    output logic [127:0]      D,
    output logic [127:0]      BWEB,
    output logic              DONE,
    output logic [ADDR_W:0]   LINES
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        fill_q, fill_d;
    logic [127:0]      line_q, line_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              ready_d, ceb_d, web_d, done_d;
    logic [ADDR_W-1:0] a_d;
    logic [127:0]      d_d, bweb_d, merged;
    logic [3:0]        fill_new;
    logic [ADDR_W:0]   lines_d;

    // Every output is a flop, so the write strobe for a line is computed on the
    // edge that accepts its final word and is visible during the WRITE cycle.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        fill_d  = fill_q;
        line_d  = line_q;
        last_d  = last_q;
        addr_d  = addr_q;
        ready_d = 1'b0;
        ceb_d   = 1'b1;
        web_d   = 1'b1;
        a_d     = A;
        d_d     = D;
        bweb_d  = '1;
        done_d  = DONE;
        lines_d = LINES;

        merged                    = line_q;
        merged[32*lane_q +: 32]   = IN_DATA;
        fill_new                  = fill_q | (4'b0001 << lane_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_FILL;
                    lane_d  = '0;
                    fill_d  = '0;
                    line_d  = '0;
                    last_d  = 1'b0;
                    addr_d  = '0;
                    lines_d = '0;
                    done_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            S_FILL: begin
                ready_d = 1'b1;
                if (IN_VALID && IN_READY) begin
                    line_d = merged;
                    fill_d = fill_new;
                    lane_d = lane_q + 2'd1;
                    last_d = IN_LAST;
                    if (lane_q == 2'd3 || IN_LAST) begin
                        state_d = S_WRITE;
                        ready_d = 1'b0;
                        ceb_d   = 1'b0;
                        web_d   = 1'b0;
                        a_d     = addr_q;
                        d_d     = merged;
                        for (int unsigned k = 0; k < 4; k++)
                            bweb_d[32*k +: 32] = {32{~fill_new[k]}};
                    end
                end
            end
            S_WRITE: begin
                lines_d = LINES + 1'b1;
                lane_d  = '0;
                fill_d  = '0;
                line_d  = '0;
                addr_d  = addr_q + 1'b1;
                if (last_q || addr_q == ADDR_W'(NUM_WORD - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FILL;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            fill_q   <= '0;
            line_q   <= '0;
            last_q   <= 1'b0;
            addr_q   <= '0;
            IN_READY <= 1'b0;
            CEB      <= 1'b1;
            WEB      <= 1'b1;
            A        <= '0;
            D        <= '0;
            BWEB     <= '1;
            DONE     <= 1'b0;
            LINES    <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            fill_q   <= fill_d;
            line_q   <= line_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            IN_READY <= ready_d;
            CEB      <= ceb_d;
            WEB      <= web_d;
            A        <= a_d;
            D        <= d_d;
            BWEB     <= bweb_d;
            DONE     <= done_d;
            LINES    <= lines_d;
        end
    end

endmodule

// File: tb/tb_input_mem_loader.sv
// Directed bench for input_mem_loader: a word-packing model queues expected
// memory writes, and a monitor pops and compares them as the writes appear.
module tb_input_mem_loader;

    logic         CLK = 1'b0;
    logic         RSTB;
    logic         START;
    logic         IN_VALID;
    logic [31:0]  IN_DATA;
    logic         IN_LAST;
    logic         IN_READY;
    logic         CEB;
    logic         WEB;
    logic [4:0]   A;
    logic [127:0] D;
    logic [127:0] BWEB;
    logic         DONE;
    logic [5:0]   LINES;

    input_mem_loader #(.NUM_WORD(32), .ADDR_W(5)) dut (
        .CLK(CLK), .RSTB(RSTB), .START(START), .IN_VALID(IN_VALID),
        .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
        .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB), .DONE(DONE),
        .LINES(LINES)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]   a;
        logic [127:0] d;
        logic [127:0] bweb;
    } wr_t;

    wr_t sb[$];
    wr_t e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int prev_wr  = -1;
    bit spacing_en = 0;

    logic [127:0] m_line;
    logic [3:0]   m_mask;
    int           m_lane;
    logic [4:0]   m_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_start();
        m_line = '0;
        m_mask = '0;
        m_lane = 0;
        m_addr = '0;
    endtask

    task automatic model_word(input logic [31:0] w, input logic l);
        wr_t x;
        m_line[32*m_lane +: 32] = w;
        m_mask[m_lane] = 1'b1;
        if (m_lane == 3 || l) begin
            x.a = m_addr;
            x.d = m_line;
            for (int k = 0; k < 4; k++) x.bweb[32*k +: 32] = m_mask[k] ? 32'h0 : 32'hFFFF_FFFF;
            sb.push_back(x);
            m_addr = m_addr + 5'd1;
            m_line = '0;
            m_mask = '0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send(input logic [31:0] w, input logic l);
        int t = 0;
        IN_VALID = 1'b1;
        IN_DATA  = w;
        IN_LAST  = l;
        while (!IN_READY && t < 50) begin
            @(negedge CLK);
            t++;
        end
        check("ready_wait", IN_READY, 1'b1);
        model_word(w, l);
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic start_load();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        model_start();
    endtask

    task automatic wait_done();
        int t = 0;
        while (!DONE && t < 20) begin
            @(negedge CLK);
            t++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, IN_READY, 1'b0);
        check({tag, "_ceb"},   CEB,      1'b1);
        check({tag, "_web"},   WEB,      1'b1);
        check({tag, "_a"},     A,        5'd0);
        check({tag, "_d"},     D,        128'd0);
        check({tag, "_bweb"},  BWEB,     {128{1'b1}});
        check({tag, "_done"},  DONE,     1'b0);
        check({tag, "_lines"}, LINES,    6'd0);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RSTB === 1'b1) begin
            if (CEB === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", CEB, 1'b1);
                end else begin
                    e = sb.pop_front();
                    check("wr_web",  WEB,  1'b0);
                    check("wr_addr", A,    e.a);
                    check("wr_data", D,    e.d);
                    check("wr_bweb", BWEB, e.bweb);
                    if (spacing_en && prev_wr >= 0) check("wr_spacing", cyc - prev_wr, 5);
                    prev_wr = cyc;
                end
            end else begin
                check("bweb_idle", BWEB, {128{1'b1}});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTB = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0;
        model_start();
        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        RSTB = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_ready", IN_READY, 1'b0);

        // Valid while idle is ignored.
        IN_VALID = 1'b1; IN_DATA = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge CLK);
            check("idle_valid_ready", IN_READY, 1'b0);
            check("idle_valid_done", DONE, 1'b0);
        end
        IN_VALID = 1'b0;

        // Full load: 128 words back to back.
        start_load();
        check("full_start_ready", IN_READY, 1'b1);
        spacing_en = 1; prev_wr = -1;
        for (int i = 0; i < 128; i++) send($urandom, 1'b0);
        wait_done();
        spacing_en = 0;
        check("full_done", DONE, 1'b1);
        check("full_lines", LINES, 6'd32);
        check("full_ready", IN_READY, 1'b0);
        check("full_sb_empty", sb.size(), 0);

        // Words offered in DONE are refused.
        IN_VALID = 1'b1; IN_LAST = 1'b1; IN_DATA = 32'h1234_5678;
        repeat (3) begin
            @(negedge CLK);
            check("done_valid_ready", IN_READY, 1'b0);
            check("done_valid_done", DONE, 1'b1);
        end
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        check("done_valid_lines", LINES, 6'd32);

        // Restart from DONE with a two-word partial line.
        start_load();
        check("restart_done_clear", DONE, 1'b0);
        check("restart_lines", LINES, 6'd0);
        check("restart_ready", IN_READY, 1'b1);
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        wait_done();
        check("partial_done", DONE, 1'b1);
        check("partial_lines", LINES, 6'd1);
        check("partial_a", A, 5'd0);
        check("partial_d", D, 128'h0000_0000_0000_0000_0000_0022_0000_0011);
        check("partial_sb_empty", sb.size(), 0);

        // Nine words with bubbles, and a START pulse mid-fill that must be ignored.
        start_load();
        for (int i = 1; i <= 9; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            send(32'h0101_0101 * i, i == 9);
            if (i == 2) begin
                START = 1'b1;
                @(negedge CLK);
                START = 1'b0;
            end
        end
        wait_done();
        check("bp_done", DONE, 1'b1);
        check("bp_lines", LINES, 6'd3);
        check("bp_sb_empty", sb.size(), 0);

        // Reset asserted mid-fill, between clock edges.
        start_load();
        send(32'hAAAA_0001, 1'b0);
        send(32'hAAAA_0002, 1'b0);
        #2 RSTB = 1'b0;
        #1 check_reset_outputs("rst_fill");
        model_start();
        @(negedge CLK);
        RSTB = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 32'h5555_5555;
        repeat (4) begin
            @(negedge CLK);
            check("rst_fill_ready_held", IN_READY, 1'b0);
        end
        IN_VALID = 1'b0;
        check("rst_fill_sb_empty", sb.size(), 0);

        // Reset asserted during the WRITE cycle: the strobe drops at once.
        start_load();
        send(32'hB0, 1'b0);
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        sb.delete();
        IN_VALID = 1'b1; IN_DATA = 32'hB3;
        @(posedge CLK);
        #1 check("rst_wr_ceb_active", CEB, 1'b0);
        RSTB = 1'b0;
        #1 check_reset_outputs("rst_wr");
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        RSTB = 1'b1;
        repeat (4) @(negedge CLK);
        check("rst_wr_lines", LINES, 6'd0);
        check("rst_wr_ceb_after", CEB, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
